ycr1_wbb_burst_master: RTL



---
 rtl/ycr1_wbb_burst_master_pkg.sv | 17 +
 rtl/ycr1_wbb_beat_cnt.sv | 25 ++
 rtl/ycr1_wbb_burst_master.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ycr1_wbb_burst_master_pkg.sv
// Shared ycr1 Wishbone burst definitions: master state encoding and default sizes.
package ycr1_wbb_burst_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } wbb_state_e;

  localparam int unsigned WBB_AW     = 32;
  localparam int unsigned WBB_DW     = 32;
  localparam int unsigned WBB_BW     = 4;
  localparam int unsigned WBB_BL     = 10;
  localparam int unsigned WBB_MAX_BL = 16;

endpackage

// File: rtl/ycr1_wbb_beat_cnt.sv
// Loadable down-counter used for both the per-burst beat count and the remaining word count.
module ycr1_wbb_beat_cnt #(
  parameter int unsigned W = 10
) (
  input  logic         wbm_clk_i,
  input  logic         wbm_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         sub,
  input  logic [W-1:0] sub_val,
  output logic [W-1:0] cnt
);

  // Load has priority so a new burst can start on the same edge the old one ends.
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (sub) begin
      cnt <= cnt - sub_val;
    end
  end

endmodule

// File: rtl/ycr1_wbb_burst_master.sv
// Wishbone burst master: splits a buffer transfer command into MAX_BL-sized bursts.
module ycr1_wbb_burst_master
  import ycr1_wbb_burst_master_pkg::*;
#(
  parameter int unsigned AW     = WBB_AW,
  parameter int unsigned DW     = WBB_DW,
  parameter int unsigned BW     = WBB_BW,
  parameter int unsigned BL     = WBB_BL,
  parameter int unsigned MAX_BL = WBB_MAX_BL
) (
  input  logic          wbm_clk_i,
  input  logic          wbm_rst_n,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [BL-1:0] cmd_len_i,
  output logic          done_o,
  output logic          err_o,
  output logic [BL-1:0] buf_addr_o,
  output logic          buf_wr_o,
  output logic [DW-1:0] buf_wdata_o,
  input  logic [DW-1:0] buf_rdata_i,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [DW-1:0] wbm_dat_o,
  output logic [BW-1:0] wbm_sel_o,
  output logic [BL-1:0] wbm_bl_o,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_lack_i,
  input  logic          wbm_err_i
);

  localparam logic [BL-1:0] MAX_BL_W = BL'(MAX_BL);

  wbb_state_e    state_q, state_d;
  logic          we_lat_q, we_lat_d;
  logic          err_d;
  logic [AW-1:0] adr_d;
  logic [BL-1:0] bl_d;
  logic [BL-1:0] buf_addr_d;
  logic          rem_load, rem_sub, beat_load;
  logic [BL-1:0] rem_cnt, beat_cnt;
  logic [BL-1:0] rem_after, beats_left;
  logic          in_burst, ack_v, lack_v, err_v;

  function automatic logic [BL-1:0] clamp_bl(input logic [BL-1:0] n);
    return (n > MAX_BL_W) ? MAX_BL_W : n;
  endfunction

  assign in_burst   = (state_q == ST_BURST);
  assign ack_v      = in_burst && wbm_ack_i;
  assign lack_v     = in_burst && wbm_lack_i;
  assign err_v      = in_burst && wbm_err_i;
  assign rem_after  = rem_cnt - wbm_bl_o;
  assign beats_left = beat_cnt - BL'(ack_v);

  // Words still to move for the whole command.
  ycr1_wbb_beat_cnt #(.W(BL)) u_rem_cnt (
    .wbm_clk_i (wbm_clk_i),
    .wbm_rst_n (wbm_rst_n),
    .load      (rem_load),
    .load_val  (cmd_len_i),
    .sub       (rem_sub),
    .sub_val   (wbm_bl_o),
    .cnt       (rem_cnt)
  );

  // Beats still expected in the current burst; must reach zero exactly on lack.
  ycr1_wbb_beat_cnt #(.W(BL)) u_beat_cnt (
    .wbm_clk_i (wbm_clk_i),
    .wbm_rst_n (wbm_rst_n),
    .load      (beat_load),
    .load_val  (bl_d),
    .sub       (ack_v),
    .sub_val   (BL'(1)),
    .cnt       (beat_cnt)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    we_lat_d   = we_lat_q;
    err_d      = err_o;
    adr_d      = wbm_adr_o;
    bl_d       = wbm_bl_o;
    buf_addr_d = buf_addr_o;
    rem_load   = 1'b0;
    rem_sub    = 1'b0;
    beat_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          if (cmd_len_i == '0) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d      = 1'b0;
            we_lat_d   = cmd_we_i;
            adr_d      = cmd_adr_i;
            bl_d       = clamp_bl(cmd_len_i);
            buf_addr_d = '0;
            rem_load   = 1'b1;
            beat_load  = 1'b1;
            state_d    = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (ack_v) begin
          buf_addr_d = buf_addr_o + BL'(1);
        end
        if (err_v) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (lack_v) begin
          if (beats_left != '0) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            rem_sub = 1'b1;
            if (rem_after != '0) begin
              adr_d     = wbm_adr_o + (AW'(wbm_bl_o) << 2);
              bl_d      = clamp_bl(rem_after);
              beat_load = 1'b1;
              state_d   = ST_GAP;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_GAP:  state_d = ST_BURST;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      state_q     <= ST_IDLE;
      we_lat_q    <= 1'b0;
      cmd_ready_o <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      buf_addr_o  <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_sel_o   <= '0;
      wbm_bl_o    <= '0;
    end else begin
      state_q     <= state_d;
      we_lat_q    <= we_lat_d;
      cmd_ready_o <= (state_d == ST_IDLE);
      done_o      <= (state_d == ST_DONE);
      err_o       <= err_d;
      buf_addr_o  <= buf_addr_d;
      wbm_cyc_o   <= (state_d == ST_BURST);
      wbm_stb_o   <= (state_d == ST_BURST);
      wbm_we_o    <= (state_d == ST_BURST) && we_lat_d;
      wbm_adr_o   <= adr_d;
      wbm_sel_o   <= (state_d == ST_BURST) ? '1 : '0;
      wbm_bl_o    <= bl_d;
    end
  end

  // Buffer data paths run straight through so an ack can complete every cycle.
  assign wbm_dat_o   = (wbm_stb_o && wbm_we_o) ? buf_rdata_i : '0;
  assign buf_wr_o    = wbm_stb_o && !wbm_we_o && wbm_ack_i;
  assign buf_wdata_o = buf_wr_o ? wbm_dat_i : '0;

endmodule
